referee_wrr: RTL and testbench
==============================

Name: referee_wrr

Overview:
- Weighted round-robin referee between four first-word-fall-through source FIFOs (VC queues) and four destination FIFOs in the PCIe transaction layer.
- Selects one source per grant and pops its head word. The word is routed to the destination FIFO named by its header destination field, with push and registered data.
- Honours destination almost_full backpressure and per-source programmable weights.

Parameters:
DATA_WIDTH, 12, width of source/destination words
WEIGHT_WIDTH, 3, width of each per-source weight (grants per turn)
DEST_LSB, 10, LSB of the 2-bit destination field data_in_k[DEST_LSB+1:DEST_LSB]

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
empty_0..empty_3  input  1 each  source FIFO k empty
data_in_0..data_in_3  input  DATA_WIDTH each  source FIFO k head word (valid when !empty_k)
almost_full_0..almost_full_3  input  1 each  destination FIFO j almost full
weight_0..weight_3  input  WEIGHT_WIDTH each  grants allowed to source k per turn; 0 = source disabled
pop_0..pop_3  output  1 each  pop source k (registered, one-hot or zero)
push_0..push_3  output  1 each  push destination j (registered, one-hot or zero)
data_out  output  DATA_WIDTH  word for the pushed destination (registered)
grant_idx  output  2  source index of current/last grant

Behaviour:
- Reset (reset=0, async) sets: pop_*=0, push_*=0, data_out=0, grant_idx=0, ptr=0, credit=0, state=LOAD.
- eligible(k) = !empty_k && !almost_full_[dest(data_in_k)].
- FSM: LOAD, SERVE, GAP.
  - LOAD: credit <= weight_[ptr]; go to SERVE. Outputs pop/push=0.
  - SERVE with eligible(ptr) && credit!=0: at the edge, pop_[ptr]<=1, push_[dest]<=1, data_out<=data_in_[ptr], grant_idx<=ptr, credit<=credit-1. Go to GAP.
  - SERVE otherwise (credit==0, source empty, or destination almost full): ptr<=ptr+1 (wrap 3->0). Go to LOAD. No pop/push.
  - GAP: pop/push/data_out-hold. pop_* and push_* deassert, data_out holds, grant_idx holds. If credit==0: ptr<=ptr+1, go to LOAD. Else go to SERVE.
- GAP exists so the source FIFO's pop takes effect and the head/empty update before the same source is re-evaluated. No word is ever popped twice.
- Throughput: at most one grant per 2 cycles. pop and the matching push are always asserted in the same cycle, exactly one of each.
- Latency: first grant occurs 2 edges after reset release with a non-empty source 0 (LOAD, then SERVE decision). pop_0/push_j are visible after the second edge.
- Weight changes take effect only at the next LOAD of that source. An in-progress turn keeps its loaded credit.
- Weight 0: source is skipped each round (LOAD then SERVE then advance, no grant).
- All sources empty: the FSM cycles LOAD/SERVE around the ring indefinitely, outputs idle.
- Backpressure: destination FIFOs set their almost_full threshold to absorb at least 2 in-flight pushes, covering the registered push plus the decision made in the same edge.
- A source blocked by almost_full loses the rest of its turn. It is served again on the next round.
- Reset asserted mid-grant: outputs clear immediately (async). No partial handshake is completed.

Optional Feature:
- Macro REFEREE_WRR_STATS_EN.
- Defined:
  - Adds outputs grant_count_0..grant_count_3 (16 bits each).
  - Each counter increments on every pop_k assertion and saturates at 16'hFFFF.
  - Counters reset to 0 with reset.
- Undefined: the ports and counters are absent. Grant behaviour is identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (LOAD=2'd0, SERVE=2'd1, GAP=2'd2).
  - NUM_VC=4.
  - Default DEST_LSB and WEIGHT_WIDTH constants.
  - Stats counter width (16).
- One natural sub-module: referee_wrr_elig, the combinational eligibility / destination decode per source (dest field extract plus almost_full mux), instantiated once per source.
- The FSM, credit and routing registers stay in the top module.

Test Plan:
- Weights 1,1,1,1; all sources non-empty; dest fields 0,1,2,3; almost_full all 0.
  - Required: pops in order 0,1,2,3,0, each separated by one GAP plus a LOAD/SERVE transition.
  - Required: push_j matches each source's dest; data_out equals that head word.
- Weights 3,1,0,2; all sources non-empty with ample data.
  - Required: per round, pops 0,0,0,1,3,3.
  - Required: pop_2 is never asserted.
  - Required: grant_count (with REFEREE_WRR_STATS_EN) equals 3:1:0:2 ratio after 10 rounds.
- Source 1 head dest=2, almost_full_2=1, others free.
  - Required: no pop_1/push_2 while asserted; sources 0,2,3 still served.
  - Release almost_full_2 -> source 1 granted in the next round.
- Sources 0 and 2 empty, 1 and 3 non-empty, weights 2 each.
  - Required: pops 1,1,3,3 repeating; no pop_0/pop_2.
- Assert reset low in the cycle pop_3=1.
  - Required: pop_3/push_* drop immediately; ptr returns to 0.
  - Required: after release, the first grant is to source 0 on the second edge.
- Change weight_0 from 1 to 4 during source 0's turn.
  - Required: current turn yields 1 grant; the next turn of source 0 yields 4.

Source files
------------

// File: rtl/referee_wrr_pkg.sv
// Shared definitions for the referee_wrr weighted round-robin referee.
// Holds the FSM state encoding, the number of virtual channels, default
// parameter values and the width of the optional per-source grant counters
// (enabled with REFEREE_WRR_STATS_EN in the top module).
package referee_wrr_pkg;

  localparam int unsigned NUM_VC           = 4;
  localparam int unsigned DEF_DEST_LSB     = 10;
  localparam int unsigned DEF_WEIGHT_WIDTH = 3;
  localparam int unsigned STATS_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/referee_wrr_elig.sv
// Per-source eligibility decode for referee_wrr.
// Extracts the 2-bit destination field from the source head word and checks
// that the source is non-empty and its destination is not almost full.
// Ports:
//   i_empty       source FIFO empty
//   i_data        source FIFO head word
//   i_almost_full almost_full flags of all destination FIFOs
//   o_dest        destination index taken from the head word
//   o_eligible    source may be granted this cycle
module referee_wrr_elig
  import referee_wrr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEST_LSB   = DEF_DEST_LSB
) (
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [NUM_VC-1:0]     i_almost_full,
  output logic [1:0]            o_dest,
  output logic                  o_eligible
);

  // Only the destination field matters here; the rest of the word is routed
  // by the top module.
  logic w_unused_data;
  assign w_unused_data = ^i_data;

  assign o_dest     = i_data[DEST_LSB +: 2];
  assign o_eligible = !i_empty && !i_almost_full[o_dest];

endmodule

// File: rtl/referee_wrr.sv
// Weighted round-robin referee between four FWFT source FIFOs and four
// destination FIFOs. A LOAD/SERVE/GAP FSM walks a pointer around the sources;
// each turn loads the source's weight as credit and grants (pop source, push
// the destination named by the head word) once per SERVE while credit remains
// and the source is eligible. GAP lets the popped FIFO update its head.
// Ports:
//   clk, reset (async, active-low)
//   empty_k, data_in_k      source FIFO k status / head word
//   almost_full_j           destination FIFO j backpressure
//   weight_k                grants per turn for source k (0 = disabled)
//   pop_k, push_j, data_out registered handshake to source/destination FIFOs
//   grant_idx               source index of the current/last grant
//   grant_count_k           saturating grant counters (REFEREE_WRR_STATS_EN only)
module referee_wrr
  import referee_wrr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int unsigned DEST_LSB     = DEF_DEST_LSB
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    empty_0,
  input  logic                    empty_1,
  input  logic                    empty_2,
  input  logic                    empty_3,
  input  logic [DATA_WIDTH-1:0]   data_in_0,
  input  logic [DATA_WIDTH-1:0]   data_in_1,
  input  logic [DATA_WIDTH-1:0]   data_in_2,
  input  logic [DATA_WIDTH-1:0]   data_in_3,
  input  logic                    almost_full_0,
  input  logic                    almost_full_1,
  input  logic                    almost_full_2,
  input  logic                    almost_full_3,
  input  logic [WEIGHT_WIDTH-1:0] weight_0,
  input  logic [WEIGHT_WIDTH-1:0] weight_1,
  input  logic [WEIGHT_WIDTH-1:0] weight_2,
  input  logic [WEIGHT_WIDTH-1:0] weight_3,
  output logic                    pop_0,
  output logic                    pop_1,
  output logic                    pop_2,
  output logic                    pop_3,
  output logic                    push_0,
  output logic                    push_1,
  output logic                    push_2,
  output logic                    push_3,
  output logic [DATA_WIDTH-1:0]   data_out,
`ifdef REFEREE_WRR_STATS_EN
  output logic [STATS_WIDTH-1:0]  grant_count_0,
  output logic [STATS_WIDTH-1:0]  grant_count_1,
  output logic [STATS_WIDTH-1:0]  grant_count_2,
  output logic [STATS_WIDTH-1:0]  grant_count_3,
`endif
  output logic [1:0]              grant_idx
);

  logic [NUM_VC-1:0]       w_empty;
  logic [NUM_VC-1:0]       w_af;
  logic [NUM_VC-1:0]       w_elig;
  logic [DATA_WIDTH-1:0]   w_data   [NUM_VC];
  logic [WEIGHT_WIDTH-1:0] w_weight [NUM_VC];
  logic [1:0]              w_dest   [NUM_VC];

  assign w_empty     = {empty_3, empty_2, empty_1, empty_0};
  assign w_af        = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};
  assign w_data[0]   = data_in_0;
  assign w_data[1]   = data_in_1;
  assign w_data[2]   = data_in_2;
  assign w_data[3]   = data_in_3;
  assign w_weight[0] = weight_0;
  assign w_weight[1] = weight_1;
  assign w_weight[2] = weight_2;
  assign w_weight[3] = weight_3;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_elig
    referee_wrr_elig #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEST_LSB   (DEST_LSB)
    ) u_elig (
      .i_empty       (w_empty[g]),
      .i_data        (w_data[g]),
      .i_almost_full (w_af),
      .o_dest        (w_dest[g]),
      .o_eligible    (w_elig[g])
    );
  end

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_ptr;
  logic [WEIGHT_WIDTH-1:0] r_credit;
  logic [NUM_VC-1:0]       r_pop;
  logic [NUM_VC-1:0]       r_push;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic [1:0]              r_grant_idx;

  logic                    w_grant;
  logic                    w_ptr_adv;
  logic [NUM_VC-1:0]       w_pop_d;
  logic [NUM_VC-1:0]       w_push_d;

  assign w_grant = (r_state == ST_SERVE) && w_elig[r_ptr] && (r_credit != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_LOAD;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = ST_LOAD;
    unique case (r_state)
      ST_LOAD:  w_next_state = ST_SERVE;
      ST_SERVE: w_next_state = w_grant ? ST_GAP : ST_LOAD;
      ST_GAP:   w_next_state = (r_credit == '0) ? ST_LOAD : ST_SERVE;
      default:  w_next_state = ST_LOAD;
    endcase
  end

  // Decode of the next registered handshake; only a SERVE grant produces one,
  // so LOAD and GAP cycles drive pop/push back to zero.
  always_comb begin
    w_pop_d   = '0;
    w_push_d  = '0;
    w_ptr_adv = ((r_state == ST_SERVE) && !w_grant) ||
                ((r_state == ST_GAP) && (r_credit == '0));
    if (w_grant) begin
      w_pop_d[r_ptr]          = 1'b1;
      w_push_d[w_dest[r_ptr]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_credit    <= '0;
      r_pop       <= '0;
      r_push      <= '0;
      r_data_out  <= '0;
      r_grant_idx <= '0;
    end else begin
      r_pop  <= w_pop_d;
      r_push <= w_push_d;
      if (r_state == ST_LOAD) r_credit <= w_weight[r_ptr];
      else if (w_grant)       r_credit <= r_credit - WEIGHT_WIDTH'(1);
      if (w_grant) begin
        r_data_out  <= w_data[r_ptr];
        r_grant_idx <= r_ptr;
      end
      if (w_ptr_adv) r_ptr <= r_ptr + 2'd1;
    end
  end

  assign {pop_3, pop_2, pop_1, pop_0}     = r_pop;
  assign {push_3, push_2, push_1, push_0} = r_push;
  assign data_out  = r_data_out;
  assign grant_idx = r_grant_idx;

`ifdef REFEREE_WRR_STATS_EN
  logic [STATS_WIDTH-1:0] r_cnt [NUM_VC];

  for (genvar g = 0; g < NUM_VC; g++) begin : g_stats
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        r_cnt[g] <= '0;
      else if (r_pop[g] && r_cnt[g] != '1) r_cnt[g] <= r_cnt[g] + STATS_WIDTH'(1);
    end
  end

  assign grant_count_0 = r_cnt[0];
  assign grant_count_1 = r_cnt[1];
  assign grant_count_2 = r_cnt[2];
  assign grant_count_3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_referee_wrr.sv
module tb_referee_wrr;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        empty_0, empty_1, empty_2, empty_3;
  logic [11:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic        almost_full_0, almost_full_1, almost_full_2, almost_full_3;
  logic [2:0]  weight_0, weight_1, weight_2, weight_3;
  logic        pop_0, pop_1, pop_2, pop_3;
  logic        push_0, push_1, push_2, push_3;
  logic [11:0] data_out;
  logic [1:0]  grant_idx;
`ifdef REFEREE_WRR_STATS_EN
  logic [15:0] grant_count_0, grant_count_1, grant_count_2, grant_count_3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last   = 0;

  // Head words: dest field is bits [11:10]
  localparam logic [11:0] D0 = 12'h011;  // dest 0
  localparam logic [11:0] D1 = 12'h422;  // dest 1
  localparam logic [11:0] D2 = 12'h833;  // dest 2
  localparam logic [11:0] D3 = 12'hC44;  // dest 3
  localparam logic [11:0] D1_TO2 = 12'h822; // source 1 head aimed at dest 2
  localparam logic [11:0] D2_TO0 = 12'h055; // source 2 head aimed at dest 0

  referee_wrr #(
    .DATA_WIDTH   (12),
    .WEIGHT_WIDTH (3),
    .DEST_LSB     (10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .empty_3       (empty_3),
    .data_in_0     (data_in_0),
    .data_in_1     (data_in_1),
    .data_in_2     (data_in_2),
    .data_in_3     (data_in_3),
    .almost_full_0 (almost_full_0),
    .almost_full_1 (almost_full_1),
    .almost_full_2 (almost_full_2),
    .almost_full_3 (almost_full_3),
    .weight_0      (weight_0),
    .weight_1      (weight_1),
    .weight_2      (weight_2),
    .weight_3      (weight_3),
    .pop_0         (pop_0),
    .pop_1         (pop_1),
    .pop_2         (pop_2),
    .pop_3         (pop_3),
    .push_0        (push_0),
    .push_1        (push_1),
    .push_2        (push_2),
    .push_3        (push_3),
    .data_out      (data_out),
`ifdef REFEREE_WRR_STATS_EN
    .grant_count_0 (grant_count_0),
    .grant_count_1 (grant_count_1),
    .grant_count_2 (grant_count_2),
    .grant_count_3 (grant_count_3),
`endif
    .grant_idx     (grant_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next handshake and check it completely, including
  // the number of cycles since the previous grant / reset release.
  task automatic expect_grant(input int k, input int j, input logic [11:0] d, input int gap);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while ({pop_3, pop_2, pop_1, pop_0} == 4'b0 &&
               {push_3, push_2, push_1, push_0} == 4'b0 && waited < 20);
    chk($sformatf("pop_src%0d", k), {28'b0, pop_3, pop_2, pop_1, pop_0}, 32'(1) << k);
    chk($sformatf("push_dst%0d", j), {28'b0, push_3, push_2, push_1, push_0}, 32'(1) << j);
    chk($sformatf("data_src%0d", k), {20'b0, data_out}, {20'b0, d});
    chk($sformatf("gidx_src%0d", k), {30'b0, grant_idx}, 32'(k));
    chk($sformatf("gap_src%0d", k), 32'(cyc - last), 32'(gap));
    last = cyc;
  endtask

  task automatic set_inputs(input logic [2:0] w0, w1, w2, w3);
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0; empty_3 = 1'b0;
    data_in_0 = D0; data_in_1 = D1; data_in_2 = D2; data_in_3 = D3;
    almost_full_0 = 1'b0; almost_full_1 = 1'b0; almost_full_2 = 1'b0; almost_full_3 = 1'b0;
    weight_0 = w0; weight_1 = w1; weight_2 = w2; weight_3 = w3;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    last  = cyc;
  endtask

  initial begin
    set_inputs(3'd1, 3'd1, 3'd1, 3'd1);

    // Reset state
    @(negedge clk);
    chk("rst_pop",  {28'b0, pop_3, pop_2, pop_1, pop_0}, 32'h0);
    chk("rst_push", {28'b0, push_3, push_2, push_1, push_0}, 32'h0);
    chk("rst_data", {20'b0, data_out}, 32'h0);
    chk("rst_gidx", {30'b0, grant_idx}, 32'h0);

    // Equal weights, one grant per source, routed by dest field
    release_reset();
    expect_grant(0, 0, D0, 2);
    expect_grant(1, 1, D1, 3);
    expect_grant(2, 2, D2, 3);
    expect_grant(3, 3, D3, 3);
    expect_grant(0, 0, D0, 3);

    // Weights 3,1,0,2: per round 0,0,0,1,3,3 and source 2 skipped
    enter_reset();
    set_inputs(3'd3, 3'd1, 3'd0, 3'd2);
    release_reset();
    for (int r = 0; r < 10; r++) begin
      expect_grant(0, 0, D0, (r == 0) ? 2 : 3);
      expect_grant(0, 0, D0, 2);
      expect_grant(0, 0, D0, 2);
      expect_grant(1, 1, D1, 3);
      expect_grant(3, 3, D3, 5);
      expect_grant(3, 3, D3, 2);
    end
`ifdef REFEREE_WRR_STATS_EN
    @(negedge clk);
    chk("cnt0", {16'b0, grant_count_0}, 32'd30);
    chk("cnt1", {16'b0, grant_count_1}, 32'd10);
    chk("cnt2", {16'b0, grant_count_2}, 32'd0);
    chk("cnt3", {16'b0, grant_count_3}, 32'd20);
`endif

    // Backpressure: source 1 targets dest 2 which is almost full
    enter_reset();
    set_inputs(3'd1, 3'd1, 3'd1, 3'd1);
    data_in_1 = D1_TO2;
    data_in_2 = D2_TO0;
    almost_full_2 = 1'b1;
    release_reset();
    expect_grant(0, 0, D0, 2);
    expect_grant(2, 0, D2_TO0, 5);
    expect_grant(3, 3, D3, 3);
    expect_grant(0, 0, D0, 5 - 2);
    expect_grant(2, 0, D2_TO0, 5);
    expect_grant(3, 3, D3, 3);
    expect_grant(0, 0, D0, 3);
    almost_full_2 = 1'b0;
    expect_grant(1, 2, D1_TO2, 3);
    expect_grant(2, 0, D2_TO0, 3);
    expect_grant(3, 3, D3, 3);

    // Sources 0 and 2 empty, weights 2
    enter_reset();
    set_inputs(3'd2, 3'd2, 3'd2, 3'd2);
    empty_0 = 1'b1;
    empty_2 = 1'b1;
    release_reset();
    expect_grant(1, 1, D1, 4);
    expect_grant(1, 1, D1, 2);
    expect_grant(3, 3, D3, 5);
    expect_grant(3, 3, D3, 2);
    expect_grant(1, 1, D1, 5);
    expect_grant(1, 1, D1, 2);
    expect_grant(3, 3, D3, 5);
    expect_grant(3, 3, D3, 2);

    // Reset asserted while pop_3 is high
    enter_reset();
    set_inputs(3'd1, 3'd1, 3'd1, 3'd1);
    release_reset();
    expect_grant(0, 0, D0, 2);
    expect_grant(1, 1, D1, 3);
    expect_grant(2, 2, D2, 3);
    expect_grant(3, 3, D3, 3);
    reset = 1'b0;
    #1;
    chk("midrst_pop",  {28'b0, pop_3, pop_2, pop_1, pop_0}, 32'h0);
    chk("midrst_push", {28'b0, push_3, push_2, push_1, push_0}, 32'h0);
    chk("midrst_data", {20'b0, data_out}, 32'h0);
    chk("midrst_gidx", {30'b0, grant_idx}, 32'h0);
    release_reset();
    expect_grant(0, 0, D0, 2);

    // weight_0 raised 1 -> 4 after source 0's credit was loaded
    enter_reset();
    set_inputs(3'd1, 3'd1, 3'd1, 3'd1);
    release_reset();
    @(negedge clk);
    weight_0 = 3'd4;
    expect_grant(0, 0, D0, 2);
    expect_grant(1, 1, D1, 3);
    expect_grant(2, 2, D2, 3);
    expect_grant(3, 3, D3, 3);
    expect_grant(0, 0, D0, 3);
    expect_grant(0, 0, D0, 2);
    expect_grant(0, 0, D0, 2);
    expect_grant(0, 0, D0, 2);
    expect_grant(1, 1, D1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
